// File: rtl/sram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// sram_arb_ctrl
//
// Two-port round-robin arbiter and timing controller for an asynchronous SRAM.
// Each access runs IDLE -> SETUP (1) -> ACCESS (ACCESS_CYC) -> HOLD (1) -> IDLE.
// Every SRAM-side output comes straight from a flop, so the pins never glitch.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req_x, we_x, addr_x, wdata_x  requester A/B access request and attributes
//   done_x                      one-cycle completion pulse (HOLD cycle)
//   rdata                       shared read data, valid while done_x is high
//   sram_address                SRAM address
//   sram_dout, sram_dout_oe     write data and its tristate enable
//   sram_din                    data returned from the SRAM pin
//   sram_ce_n/we_n/oe_n         active-low chip, write and output enables
// ---------------------------------------------------------------------------
module sram_arb_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 8,
    parameter int ACCESS_CYC = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_a,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] wdata_a,
    input  logic                  req_b,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] wdata_b,
    output logic                  done_a,
    output logic                  done_b,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic [ADDR_WIDTH-1:0] sram_address,
    output logic [DATA_WIDTH-1:0] sram_dout,
    output logic                  sram_dout_oe,
    input  logic [DATA_WIDTH-1:0] sram_din,
    output logic                  sram_ce_n,
    output logic                  sram_we_n,
    output logic                  sram_oe_n
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

    localparam logic [3:0] LAST_CNT = 4'(ACCESS_CYC - 1);

    state_t                  state_reg, state_next;
    logic [3:0]              cnt_reg, cnt_next;
    logic                    last_b_reg, last_b_next;   // 1: B was granted last
    logic                    owner_b_reg, owner_b_next; // owner of current access
    logic                    we_reg, we_next;           // latched direction
    logic [ADDR_WIDTH-1:0]   addr_next;
    logic [DATA_WIDTH-1:0]   dout_next;
    logic                    ce_n_next, we_n_next, oe_n_next, dout_oe_next;
    logic                    done_a_next, done_b_next;
    logic                    grant_a, grant_b;
    logic                    capture;

    // Next-state, grant and latch logic. The address and write data are held
    // directly in the output registers, loaded only on a grant, which keeps
    // them stable from SETUP through HOLD.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        last_b_next  = last_b_reg;
        owner_b_next = owner_b_reg;
        we_next      = we_reg;
        addr_next    = sram_address;
        dout_next    = sram_dout;
        grant_a      = 1'b0;
        grant_b      = 1'b0;
        case (state_reg)
            IDLE: begin
                grant_a = req_a && (!req_b || last_b_reg);
                grant_b = req_b && !grant_a;
                if (grant_a) begin
                    state_next   = SETUP;
                    owner_b_next = 1'b0;
                    last_b_next  = 1'b0;
                    we_next      = we_a;
                    addr_next    = addr_a;
                    dout_next    = wdata_a;
                end else if (grant_b) begin
                    state_next   = SETUP;
                    owner_b_next = 1'b1;
                    last_b_next  = 1'b1;
                    we_next      = we_b;
                    addr_next    = addr_b;
                    dout_next    = wdata_b;
                end
            end
            SETUP: begin
                state_next = ACCESS;
                cnt_next   = 4'd0;
            end
            ACCESS: begin
                if (cnt_reg == LAST_CNT) begin
                    state_next = HOLD;
                end else begin
                    cnt_next = cnt_reg + 4'd1;
                end
            end
            default: state_next = IDLE;  // HOLD
        endcase
    end

    // Strobes are decoded from the state being entered and registered, so the
    // pins reflect the current state without any combinational path.
    always_comb begin
        ce_n_next    = 1'b1;
        we_n_next    = 1'b1;
        oe_n_next    = 1'b1;
        dout_oe_next = 1'b0;
        done_a_next  = 1'b0;
        done_b_next  = 1'b0;
        case (state_next)
            SETUP: begin
                ce_n_next    = 1'b0;
                oe_n_next    = we_next;
                dout_oe_next = we_next;
            end
            ACCESS: begin
                ce_n_next    = 1'b0;
                we_n_next    = !we_next;
                oe_n_next    = we_next;
                dout_oe_next = we_next;
            end
            HOLD: begin
                ce_n_next    = 1'b0;
                dout_oe_next = we_next;
                done_a_next  = !owner_b_next;
                done_b_next  = owner_b_next;
            end
            default: ;
        endcase
    end

    // Read data is sampled at the edge that ends the last ACCESS cycle.
    assign capture = (state_reg == ACCESS) && (cnt_reg == LAST_CNT) && !we_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cnt_reg      <= 4'd0;
            last_b_reg   <= 1'b1;
            owner_b_reg  <= 1'b0;
            we_reg       <= 1'b0;
            sram_address <= '0;
            sram_dout    <= '0;
            sram_ce_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_dout_oe <= 1'b0;
            done_a       <= 1'b0;
            done_b       <= 1'b0;
            rdata        <= '0;
        end else begin
            state_reg    <= state_next;
            cnt_reg      <= cnt_next;
            last_b_reg   <= last_b_next;
            owner_b_reg  <= owner_b_next;
            we_reg       <= we_next;
            sram_address <= addr_next;
            sram_dout    <= dout_next;
            sram_ce_n    <= ce_n_next;
            sram_we_n    <= we_n_next;
            sram_oe_n    <= oe_n_next;
            sram_dout_oe <= dout_oe_next;
            done_a       <= done_a_next;
            done_b       <= done_b_next;
            if (capture) begin
                rdata <= sram_din;
            end
        end
    end

endmodule

// File: tb/tb_sram_arb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_arb_ctrl
//
// Drives sram_arb_ctrl (ACCESS_CYC=2) against a behavioural SRAM and a
// reference memory / round-robin model, plus a second instance with
// ACCESS_CYC=1 for back-to-back reads. Inputs are driven and outputs sampled
// on the falling edge, so each falling edge is one observation of a cycle.
// ---------------------------------------------------------------------------
module tb_sram_arb_ctrl;

    localparam int AC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_a, we_a, req_b, we_b;
    logic [7:0]  addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic        done_a, done_b;
    logic [15:0] rdata;
    logic [7:0]  sram_address;
    logic [15:0] sram_dout, sram_din;
    logic        sram_dout_oe, sram_ce_n, sram_we_n, sram_oe_n;

    logic        req_a2, we_a2;
    logic [7:0]  addr_a2;
    logic [15:0] wdata_a2;
    logic        done_a2, done_b2;
    logic [15:0] rdata2;
    logic [7:0]  sram_address2;
    logic [15:0] sram_dout2, sram_din2;
    logic        sram_dout_oe2, sram_ce_n2, sram_we_n2, sram_oe_n2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    sram_arb_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .ACCESS_CYC(AC)) dut (
        .clk(clk), .reset(reset),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .done_a(done_a), .done_b(done_b), .rdata(rdata),
        .sram_address(sram_address), .sram_dout(sram_dout),
        .sram_dout_oe(sram_dout_oe), .sram_din(sram_din),
        .sram_ce_n(sram_ce_n), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    sram_arb_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .ACCESS_CYC(1)) dut2 (
        .clk(clk), .reset(reset),
        .req_a(req_a2), .we_a(we_a2), .addr_a(addr_a2), .wdata_a(wdata_a2),
        .req_b(1'b0), .we_b(1'b0), .addr_b(8'h00), .wdata_b(16'h0000),
        .done_a(done_a2), .done_b(done_b2), .rdata(rdata2),
        .sram_address(sram_address2), .sram_dout(sram_dout2),
        .sram_dout_oe(sram_dout_oe2), .sram_din(sram_din2),
        .sram_ce_n(sram_ce_n2), .sram_we_n(sram_we_n2), .sram_oe_n(sram_oe_n2)
    );

    // Power-on contents of the SRAM model after its reset pulse.
    function automatic logic [15:0] preload(input logic [7:0] a);
        return {a, a} ^ 16'h4B05;
    endfunction

    // Behavioural asynchronous SRAM.
    logic [15:0] mem [256];
    logic        sram_rst;
    always @(posedge clk) begin
        if (sram_rst) begin
            for (int i = 0; i < 256; i++) mem[i] <= preload(8'(i));
        end else if (!sram_ce_n && !sram_we_n && sram_dout_oe) begin
            mem[sram_address] <= sram_dout;
        end
    end
    assign sram_din  = (!sram_ce_n && !sram_oe_n) ? mem[sram_address] : 16'hxxxx;
    assign sram_din2 = (!sram_ce_n2 && !sram_oe_n2) ? preload(sram_address2) : 16'hxxxx;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: expected memory contents and last-granted port.
    logic [15:0] ref_mem [256];
    bit          last_was_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Protocol monitor: strobe exclusivity, address stability, single done.
    logic       prev_ce_low = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            chk("inv_we_oe", 32'(!sram_we_n && !sram_oe_n), 32'd0);
            chk("inv_drive_oe", 32'(sram_dout_oe && !sram_oe_n), 32'd0);
            chk("done_excl", 32'(done_a && done_b), 32'd0);
            if (!sram_ce_n && prev_ce_low) chk("addr_stable", 32'(sram_address), 32'(prev_addr));
            chk("inv2_we_oe", 32'(!sram_we_n2 && !sram_oe_n2), 32'd0);
            chk("inv2_drive", 32'(sram_dout_oe2), 32'd0);
            chk("dut2_dout", 32'(sram_dout2), 32'd0);
            chk("dut2_done_b", 32'(done_b2), 32'd0);
        end
        prev_ce_low = !sram_ce_n;
        prev_addr   = sram_address;
    end

    // One or two requests issued together at cycle 0 (DUT in IDLE), checked
    // cycle by cycle against the access timing, then left in the next IDLE.
    task automatic run_pair(input bit ra, input bit rb, input bit wa, input bit wb,
                            input logic [7:0] aa, input logic [7:0] ab,
                            input logic [15:0] da, input logic [15:0] db);
        bit both, win_b, sb, swe;
        logic [7:0]  sadr;
        logic [15:0] sdat;
        int n, j;
        both  = ra && rb;
        win_b = both ? !last_was_b : rb;
        n     = both ? 2 * AC + 5 : AC + 2;
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        for (int k = 0; k <= n; k++) begin
            if (k > 0) @(negedge clk);
            if (k <= AC + 2) begin j = k; sb = win_b; end
            else begin j = k - (AC + 3); sb = !win_b; end
            swe  = sb ? wb : wa;
            sadr = sb ? ab : aa;
            sdat = sb ? db : da;
            chk("ce_n", 32'(sram_ce_n), 32'(!(j >= 1)));
            chk("we_n", 32'(sram_we_n), 32'(!(swe && j >= 2 && j <= AC + 1)));
            chk("oe_n", 32'(sram_oe_n), 32'(!(!swe && j >= 1 && j <= AC + 1)));
            chk("dout_oe", 32'(sram_dout_oe), 32'(swe && j >= 1));
            chk("done_a", 32'(done_a), 32'(j == AC + 2 && !sb));
            chk("done_b", 32'(done_b), 32'(j == AC + 2 && sb));
            if (j >= 1) chk("address", 32'(sram_address), 32'(sadr));
            if (swe && j >= 1) chk("wdata", 32'(sram_dout), 32'(sdat));
            // Inputs of the granted port change after the grant; must be ignored.
            if (j == 1 && k <= AC + 2) begin
                if (sb) begin addr_b = 8'($urandom); wdata_b = 16'($urandom); end
                else    begin addr_a = 8'($urandom); wdata_a = 16'($urandom); end
            end
            if (j == AC + 2) begin
                if (swe) ref_mem[sadr] = sdat;
                else chk("rdata", 32'(rdata), 32'(ref_mem[sadr]));
                if (sb) req_b = 1'b0; else req_a = 1'b0;
                last_was_b = sb;
                $display("txn port=%s we=%0d addr=%02h data=%04h rdata=%04h cycle=%0d",
                         sb ? "B" : "A", swe, sadr, sdat, rdata, cyc);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; sram_rst = 1'b1;
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
        req_a2 = 0; we_a2 = 0; addr_a2 = 0; wdata_a2 = 0;
        for (int i = 0; i < 256; i++) ref_mem[i] = preload(8'(i));
        last_was_b = 1'b1;
        repeat (3) @(negedge clk);
        sram_rst = 1'b0;

        // Reset values.
        chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_dout_oe", 32'(sram_dout_oe), 32'd0);
        chk("rst_dout", 32'(sram_dout), 32'd0);
        chk("rst_addr", 32'(sram_address), 32'd0);
        chk("rst_done", 32'({done_a, done_b}), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst2_strobes", 32'({sram_ce_n2, sram_we_n2, sram_oe_n2}), 32'd7);
        reset = 1'b0; mon_en = 1'b1;

        // Write then read back, first grant in the first cycle out of reset.
        run_pair(1, 0, 1, 0, 8'h32, 8'h00, 16'hBEEF, 16'h0000);
        run_pair(1, 0, 0, 0, 8'h32, 8'h00, 16'h0000, 16'h0000);
        chk("rdata_beef_hold", 32'(rdata), 32'h0000BEEF);

        // Preloaded read from B.
        sram_rst = 1'b1; @(negedge clk); sram_rst = 1'b0; @(negedge clk);
        for (int i = 0; i < 256; i++) ref_mem[i] = preload(8'(i));
        run_pair(0, 1, 0, 0, 8'h00, 8'h7C, 16'h0000, 16'h0000);
        chk("rdata_preload", 32'(rdata), 32'h00003779);

        // Ties: after B, A wins; after a lone A access, B wins.
        run_pair(1, 1, 1, 1, 8'h10, 8'h11, 16'h1111, 16'h2222);
        run_pair(1, 0, 0, 0, 8'h10, 8'h00, 16'h0000, 16'h0000);
        run_pair(1, 1, 0, 0, 8'h11, 8'h10, 16'h0000, 16'h0000);

        // Reset during the ACCESS phase of a write aborts it with no done.
        req_a = 1; we_a = 1; addr_a = 8'h20; wdata_a = 16'h5A5A;
        @(negedge clk); @(negedge clk);
        reset = 1'b1; req_a = 1'b0;
        @(negedge clk);
        chk("abort_strobes", 32'({sram_ce_n, sram_we_n, sram_oe_n}), 32'd7);
        chk("abort_dout_oe", 32'(sram_dout_oe), 32'd0);
        chk("abort_done", 32'({done_a, done_b}), 32'd0);
        chk("abort_addr", 32'(sram_address), 32'd0);
        reset = 1'b0; last_was_b = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("abort_no_done", 32'({done_a, done_b}), 32'd0);
        end
        run_pair(1, 1, 1, 1, 8'h20, 8'h21, 16'hA0A0, 16'hB1B1);

        // Randomized traffic against the reference model.
        for (int t = 0; t < 40; t++) begin
            bit ra, rb;
            ra = 1'($urandom); rb = 1'($urandom);
            if (!ra && !rb) ra = 1'b1;
            run_pair(ra, rb, 1'($urandom), 1'($urandom),
                     8'($urandom_range(0, 31)), 8'($urandom_range(0, 31)),
                     16'($urandom), 16'($urandom));
        end

        // ACCESS_CYC=1: reads from A held back to back, done every 4 cycles.
        req_a2 = 1'b1; we_a2 = 1'b0; addr_a2 = 8'h7C;
        for (int k = 0; k <= 11; k++) begin
            if (k > 0) @(negedge clk);
            chk("ac1_done_a", 32'(done_a2), 32'(k >= 3 && (k - 3) % 4 == 0));
            if (done_a2) begin
                chk("ac1_rdata", 32'(rdata2), 32'h00003779);
                $display("txn ac1 port=A addr=7c rdata=%04h cycle=%0d", rdata2, cyc);
            end
            if (k == 11) req_a2 = 1'b0;
        end
        repeat (2) @(negedge clk);
        chk("ac1_idle_done", 32'(done_a2), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
